universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 92 +++++++++
 tb/tb_universal_shift_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit bidirectional shift register with hold,
// parallel load, serial-in or rotate shifting, and a saturating count of
// shifts since the last load or reset.
module universal_shift_reg #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic                           rotate,
  input  logic                           serial_in_left,
  input  logic                           serial_in_right,
  input  logic [WIDTH-1:0]               d,
  output logic [WIDTH-1:0]               q,
  output logic [WIDTH-1:0]               q_not,
  output logic [$clog2(WIDTH+1)-1:0]     shift_count,
  output logic                           drained
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  mode_t          op;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    count_next;
  logic             in_msb;
  logic             in_lsb;

  assign op = mode_t'(mode);

  // Select the bit entering each end: recirculated bit when rotating, else serial input.
  always_comb begin
    in_msb = serial_in_left;
    in_lsb = serial_in_right;
    if (rotate) begin
      in_msb = q[0];
      in_lsb = q[WIDTH-1];
    end
  end

  // Next register contents and shift count for the selected operation.
  always_comb begin
    q_next     = q;
    count_next = shift_count;
    unique case (op)
      MODE_HOLD: begin
        q_next     = q;
        count_next = shift_count;
      end
      MODE_RIGHT: begin
        q_next     = {in_msb, q[WIDTH-1:1]};
        count_next = (shift_count == FULL) ? FULL : shift_count + 1'b1;
      end
      MODE_LEFT: begin
        q_next     = {q[WIDTH-2:0], in_lsb};
        count_next = (shift_count == FULL) ? FULL : shift_count + 1'b1;
      end
      MODE_LOAD: begin
        q_next     = d;
        count_next = '0;
      end
      default: begin
        q_next     = q;
        count_next = shift_count;
      end
    endcase
  end

  // State register: async reset, enable gates every update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q           <= RESET_VALUE;
      shift_count <= '0;
    end else if (enable) begin
      q           <= q_next;
      shift_count <= count_next;
    end
  end

  assign q_not   = ~q;
  assign drained = (shift_count == FULL);

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed scenarios plus randomized stimulus checked
// against an arithmetic reference model; a second instance covers RESET_VALUE.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic       rotate;
  logic       sil;
  logic       sir;
  logic [7:0] d;

  logic [7:0] q0, qn0, q1, qn1;
  logic [3:0] sc0, sc1;
  logic       dr0, dr1;

  int nchecks = 0;
  int nfail   = 0;

  // Reference model state
  logic [7:0] mq0, mq1;
  int         mcnt;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .rotate(rotate),
    .serial_in_left(sil), .serial_in_right(sir), .d(d),
    .q(q0), .q_not(qn0), .shift_count(sc0), .drained(dr0)
  );

  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hC3)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .rotate(rotate),
    .serial_in_left(sil), .serial_in_right(sir), .d(d),
    .q(q1), .q_not(qn1), .shift_count(sc1), .drained(dr1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register value after one enabled edge, from the plain shift rules.
  function automatic logic [7:0] model_next(input logic [7:0] c);
    int v;
    int b;
    v = int'(c);
    case (mode)
      2'b01: begin
        b = rotate ? (v % 2) : int'(sil);
        v = (v / 2) + b * 128;
      end
      2'b10: begin
        b = rotate ? (v / 128) : int'(sir);
        v = ((v * 2) % 256) + b;
      end
      2'b11: v = int'(d);
      default: v = v;
    endcase
    return v[7:0];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_q"},       {56'd0, q0},  {56'd0, mq0});
    check({tag, "_qn"},      {56'd0, qn0}, {56'd0, ~mq0});
    check({tag, "_cnt"},     {60'd0, sc0}, 64'(mcnt));
    check({tag, "_drained"}, {63'd0, dr0}, {63'd0, (mcnt == 8)});
    check({tag, "_q_rv"},    {56'd0, q1},  {56'd0, mq1});
    check({tag, "_qn_rv"},   {56'd0, qn1}, {56'd0, ~mq1});
    check({tag, "_cnt_rv"},  {60'd0, sc1}, 64'(mcnt));
  endtask

  // One clock edge with the currently driven inputs; model advances alongside.
  task automatic tick(input string tag);
    logic [7:0] n0, n1;
    int         nc;
    n0 = mq0; n1 = mq1; nc = mcnt;
    if (enable && !reset) begin
      n0 = model_next(mq0);
      n1 = model_next(mq1);
      if (mode == 2'b11) nc = 0;
      else if (mode != 2'b00) nc = (mcnt < 8) ? mcnt + 1 : 8;
    end
    @(posedge clk);
    #1;
    mq0 = n0; mq1 = n1; mcnt = nc;
    check_all(tag);
  endtask

  task automatic set_in(input logic en, input logic [1:0] m, input logic rot,
                        input logic l, input logic r, input logic [7:0] dv);
    enable = en; mode = m; rotate = rot; sil = l; sir = r; d = dv;
  endtask

  // Asynchronous reset pulse between edges; held through one edge with live inputs.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    mq0 = 8'h00; mq1 = 8'hC3; mcnt = 0;
    check({tag, "_async_q"},  {56'd0, q0},  64'h00);
    check({tag, "_async_qn"}, {56'd0, qn0}, 64'hFF);
    check({tag, "_async_rv"}, {56'd0, q1},  64'hC3);
    check({tag, "_async_rvn"},{56'd0, qn1}, 64'h3C);
    check_all({tag, "_async"});
    set_in(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'h77);
    @(posedge clk);
    #1;
    check_all({tag, "_hold"});
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    mq0 = 8'h00; mq1 = 8'hC3; mcnt = 0;
    #2;
    check_all("por");
    @(posedge clk);
    #1;
    check_all("por_edge");
    reset = 1'b0;

    // Async reset mid-sequence
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C); tick("ld3c");
    check("ld3c_exp", {56'd0, q0}, 64'h3C);
    set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00); tick("sh1");
    tick("sh2");
    check("sh2_cnt", {60'd0, sc0}, 64'd2);
    pulse_reset("r1");
    set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00); tick("resume");
    check("resume_q", {56'd0, q0}, 64'h01);
    check("resume_cnt", {60'd0, sc0}, 64'd1);

    // Load and shift right with serial input
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5); tick("lda5");
    set_in(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00); tick("shr");
    check("shr_q", {56'd0, q0}, 64'hD2);
    check("shr_qn", {56'd0, qn0}, 64'h2D);
    check("shr_cnt", {60'd0, sc0}, 64'd1);

    // Rotate left full circle
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h81); tick("ld81");
    set_in(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      tick("rotl");
      if (i == 1) check("rotl_first", {56'd0, q0}, 64'h03);
      if (i == 7) check("rotl_not_drained", {63'd0, dr0}, 64'd0);
    end
    check("rotl_last", {56'd0, q0}, 64'h81);
    check("rotl_drained", {63'd0, dr0}, 64'd1);

    // Enable gating
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h5A); tick("ld5a");
    set_in(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00); tick("pre_gate");
    set_in(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) tick("gated");
    check("gated_q", {56'd0, q0}, 64'h2D);
    check("gated_cnt", {60'd0, sc0}, 64'd1);
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h5A); tick("ld5a2");
    set_in(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) tick("gated2");
    check("gated2_q", {56'd0, q0}, 64'h5A);
    check("gated2_cnt", {60'd0, sc0}, 64'd0);

    // Saturation
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00); tick("ld00");
    set_in(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      tick("sat");
      if (i == 1) check("sat_first", {56'd0, q0}, 64'h80);
      if (i >= 8) begin
        check("sat_q", {56'd0, q0}, 64'hFF);
        check("sat_cnt", {60'd0, sc0}, 64'd8);
        check("sat_drained", {63'd0, dr0}, 64'd1);
      end
    end
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h12); tick("ld12");
    check("ld12_cnt", {60'd0, sc0}, 64'd0);
    check("ld12_drained", {63'd0, dr0}, 64'd0);

    // Randomized operation with occasional async reset
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      // Bias toward shifts so saturation is reached often
      if (mode == 2'b11 && $urandom_range(0, 2) != 0) mode = 2'($urandom_range(1, 2));
      tick("rnd");
      if ($urandom_range(0, 39) == 0) pulse_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
